// File: rtl/lib_sdiv27d9_if.sv
// lib_sdiv27d9_if: start/operand request and result bus of the signed divider
interface lib_sdiv27d9_if #(
    parameter int Na = 27,
    parameter int Nb = 9
);
    logic          start;
    logic [Na-1:0] a;
    logic [Nb-1:0] b;
    logic          busy;
    logic          out_valid;
    logic [Na-1:0] quo;
    logic [Nb-1:0] rem;
    logic          dz;
    logic          ovf;
    modport master (output start, a, b, input busy, out_valid, quo, rem, dz, ovf);
    modport slave  (input start, a, b, output busy, out_valid, quo, rem, dz, ovf);
endinterface

// File: rtl/lib_sdiv27d9.sv
// lib_sdiv27d9: sign-magnitude restoring divider, one quotient bit per clock
module lib_sdiv27d9 #(
    parameter int Na = 27,
    parameter int Nb = 9
) (
    input logic           clk,
    input logic           rst_n,
    lib_sdiv27d9_if.slave bus
);
    localparam int CW = $clog2(Na + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t        state;
    logic [Na-1:0] q;
    logic [Nb-1:0] r;
    logic [Nb-1:0] mb;
    logic          sa;
    logic          sb;
    logic          zb;
    logic [CW-1:0] cnt;
    logic [Na-1:0] ma_in;
    logic [Nb-1:0] mb_in;
    logic [Nb:0]   t;
    logic          ge;
    logic [Na-1:0] qs;
    logic [Nb-1:0] rs;
    // q starts as |a| and shifts out dividend bits while quotient bits shift in
    always_comb begin
        ma_in = bus.a[Na-1] ? ~bus.a + Na'(1) : bus.a;
        mb_in = bus.b[Nb-1] ? ~bus.b + Nb'(1) : bus.b;
        t     = {r, q[Na-1]};
        ge    = t >= {1'b0, mb};
        qs    = (sa ^ sb) ? ~q + Na'(1) : q;
        rs    = sa ? ~r + Nb'(1) : r;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.quo       <= '0;
            bus.rem       <= '0;
            bus.dz        <= 1'b0;
            bus.ovf       <= 1'b0;
            cnt           <= '0;
            q             <= '0;
            r             <= '0;
            mb            <= '0;
            sa            <= 1'b0;
            sb            <= 1'b0;
            zb            <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    q        <= ma_in;
                    mb       <= mb_in;
                    sa       <= bus.a[Na-1];
                    sb       <= bus.b[Nb-1];
                    zb       <= bus.b == '0;
                    cnt      <= CW'(Na);
                    r        <= '0;
                    bus.busy <= 1'b1;
                    state    <= (bus.b == '0) ? FIX : CALC;
                end
                CALC: begin
                    r     <= ge ? Nb'(t - {1'b0, mb}) : t[Nb-1:0];
                    q     <= {q[Na-2:0], ge};
                    cnt   <= cnt - CW'(1);
                    state <= (cnt == CW'(1)) ? FIX : CALC;
                end
                FIX: begin
                    // a positive quotient with its MSB set only arises from -2^(Na-1) / -1
                    bus.quo       <= zb ? '0 : qs;
                    bus.rem       <= zb ? '0 : rs;
                    bus.dz        <= zb;
                    bus.ovf       <= !zb && !(sa ^ sb) && q[Na-1];
                    bus.out_valid <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
